// File: rtl/fptd_iter_ctrl.sv
// Iteration and Razor-replay controller for a K-section FPTD array: steps the
// array, stalls it for a replay window on timing errors, and forms hard decisions.
module fptd_iter_ctrl #(
  parameter int K            = 8,
  parameter int M            = 6,
  parameter int MaxIter      = 8,
  parameter int ReplayCycles = 2
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             start,
  input  logic [K-1:0]     Error_Section,
  input  logic [K*M-1:0]   be1_in,
  input  logic [K*M-1:0]   bs,
  input  logic [K*M-1:0]   ba1,
  output logic             section_en,
  output logic             clear_state,
  output logic             busy,
  output logic [K*M-1:0]   be1_buf,
  output logic [K-1:0]     hard_bit,
  output logic             done,
  output logic [7:0]       err_count,
  output logic [2:0]       dbg_state_o
);

  // Handshake: start is sampled only while busy is low (IDLE); there is no
  // ready/ack, so a start seen while busy is high is dropped.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_REPLAY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] LastStep = 8'(2 * MaxIter - 1);

  state_t           state_q, state_d;
  logic [7:0]       step_q, step_d;
  logic [3:0]       rep_q, rep_d;
  logic [7:0]       err_q, err_d;
  logic [K*M-1:0]   buf_q, buf_d;
  logic [K-1:0]     hard_q, hard_d;
  logic [K-1:0]     hard_calc;

  function automatic logic [M+1:0] sext(input logic [M-1:0] v);
    return {{2{v[M-1]}}, v};
  endfunction

  // Two extra bits keep the three-way sum of M-bit values from overflowing.
  for (genvar g = 0; g < K; g++) begin : g_sum
    logic [M+1:0] sum;
    assign sum = sext(bs[g*M +: M]) + sext(ba1[g*M +: M]) + sext(buf_q[g*M +: M]);
    assign hard_calc[g] = sum[M+1];
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rep_d       = rep_q;
    err_d       = err_q;
    buf_d       = buf_q;
    hard_d      = hard_q;
    section_en  = 1'b0;
    clear_state = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_CLEAR;
          step_d  = '0;
          err_d   = '0;
        end
      end
      S_CLEAR: begin
        clear_state = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        section_en = 1'b1;
        if (|Error_Section) begin
          // Errored step is discarded and rerun after the replay window.
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          rep_d   = 4'(ReplayCycles);
          state_d = S_REPLAY;
        end else begin
          buf_d  = be1_in;
          step_d = step_q + 8'd1;
          if (step_q == LastStep) state_d = S_DONE;
        end
      end
      S_REPLAY: begin
        rep_d = rep_q - 4'd1;
        if (rep_q <= 4'd1) state_d = S_RUN;
      end
      S_DONE: begin
        done    = 1'b1;
        hard_d  = hard_calc;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      rep_q   <= '0;
      err_q   <= '0;
      buf_q   <= '0;
      hard_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      hard_q  <= hard_d;
    end
  end

  assign be1_buf     = buf_q;
  assign hard_bit    = hard_q;
  assign err_count   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fptd_iter_ctrl.sv
// Directed bench for fptd_iter_ctrl: table of clean frames plus hand-written
// error, replay, saturation and reset sequences (K=4, M=6, MaxIter=2, Replay=2).
module tb_fptd_iter_ctrl;
  localparam int K = 4;
  localparam int M = 6;
  localparam int W = K * M;

  logic           Clock = 1'b0;
  logic           nReset;
  logic           start;
  logic [K-1:0]   Error_Section;
  logic [W-1:0]   be1_in, bs, ba1;
  logic           section_en, clear_state, busy, done;
  logic [W-1:0]   be1_buf;
  logic [K-1:0]   hard_bit;
  logic [7:0]     err_count;
  logic [2:0]     dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  fptd_iter_ctrl #(.K(K), .M(M), .MaxIter(2), .ReplayCycles(2)) dut (
    .Clock(Clock), .nReset(nReset), .start(start), .Error_Section(Error_Section),
    .be1_in(be1_in), .bs(bs), .ba1(ba1), .section_en(section_en),
    .clear_state(clear_state), .busy(busy), .be1_buf(be1_buf),
    .hard_bit(hard_bit), .done(done), .err_count(err_count), .dbg_state_o(dbg_state)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0] be1;
    logic [W-1:0] bsv;
    logic [W-1:0] ba1v;
    logic [K-1:0] exp_hard;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [W-1:0] v;
    v[5:0]   = a0[5:0];
    v[11:6]  = a1[5:0];
    v[17:12] = a2[5:0];
    v[23:18] = a3[5:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Runs one frame from IDLE; returns observed timing and be1_buf one cycle
  // after the injected error cycle. Ends one cycle after done.
  task automatic run_frame(input logic [W-1:0] be1, input logic [W-1:0] bs_v,
                           input logic [W-1:0] ba1_v, input int err_cyc,
                           input logic [K-1:0] err_val, input logic [W-1:0] be1_err,
                           input int start2_cyc, output int clr_cyc, output int en_cnt,
                           output int done_cyc, output logic [W-1:0] buf_after_err);
    bs = bs_v;
    ba1 = ba1_v;
    clr_cyc = -1;
    en_cnt = 0;
    done_cyc = -1;
    buf_after_err = '0;
    for (int c = 0; c < 200; c++) begin
      start = (c == 0 || c == start2_cyc);
      Error_Section = (c == err_cyc) ? err_val : '0;
      be1_in = (c == err_cyc) ? be1_err : be1;
      if (c == err_cyc + 1) buf_after_err = be1_buf;
      if (clear_state) clr_cyc = c;
      if (section_en) en_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    start = 1'b0;
    Error_Section = '0;
    tick();
  endtask

  int clr_c, en_c, done_c, done_seen;
  logic [W-1:0] buf_e;
  logic [W-1:0] pat_a, pat_b;

  initial begin
    vecs[0] = '{pack4(5, -3, 0, -1), '0, '0, 4'b1010};
    vecs[1] = '{pack4(-32, -32, 0, 0), pack4(-32, -32, 31, -31), pack4(-32, -32, -31, 31), 4'b0011};
    vecs[2] = '{pack4(-2, 0, 1, -6), pack4(1, 0, -1, 10), pack4(0, 0, 0, -5), 4'b1001};
    vecs[3] = '{pack4(31, -32, 0, -31), pack4(31, 31, 31, 31), pack4(31, 31, 31, 31), 4'b0000};
    pat_a = pack4(7, -7, 12, -20);
    pat_b = pack4(-1, 1, -2, 2);

    nReset = 1'b0;
    start = 1'b0;
    Error_Section = '0;
    be1_in = '0;
    bs = '0;
    ba1 = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_outs", {section_en, clear_state, done, dbg_state}, 0);
    check("rst_buf", be1_buf, 0);
    check("rst_hard_err", {hard_bit, err_count}, 0);
    @(negedge Clock);
    nReset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].be1, vecs[i].bsv, vecs[i].ba1v, -10, '0, '0, -10,
                clr_c, en_c, done_c, buf_e);
      check($sformatf("v%0d_clear_cyc", i), clr_c, 1);
      check($sformatf("v%0d_en_cycles", i), en_c, 4);
      check($sformatf("v%0d_done_cyc", i), done_c, 6);
      check($sformatf("v%0d_busy_after", i), busy, 0);
      check($sformatf("v%0d_hard_bit", i), hard_bit, vecs[i].exp_hard);
      check($sformatf("v%0d_err_count", i), err_count, 0);
      check($sformatf("v%0d_be1_buf", i), be1_buf, vecs[i].be1);
    end

    // Error in second RUN cycle: be1_buf must not take the errored value.
    run_frame(pat_a, '0, '0, 3, 4'b0100, pat_b, -10, clr_c, en_c, done_c, buf_e);
    check("err1_done_cyc", done_c, 9);
    check("err1_en_cycles", en_c, 5);
    check("err1_err_count", err_count, 1);
    check("err1_buf_hold", buf_e, pat_a);
    check("err1_be1_buf", be1_buf, pat_a);

    // Error on the final step delays done by one replay plus one clean step.
    run_frame(pat_a, '0, '0, 5, 4'b0001, pat_b, -10, clr_c, en_c, done_c, buf_e);
    check("errlast_done_cyc", done_c, 9);
    check("errlast_err_count", err_count, 1);
    check("errlast_be1_buf", be1_buf, pat_a);

    // start during RUN is ignored.
    run_frame(vecs[0].be1, '0, '0, -10, '0, '0, 3, clr_c, en_c, done_c, buf_e);
    check("start_ign_done_cyc", done_c, 6);
    check("start_ign_en_cycles", en_c, 4);
    check("start_ign_idle", dbg_state, 0);
    check("start_ign_hard", hard_bit, 4'b1010);

    // Reset mid-RUN after an error and captures.
    be1_in = pat_a;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    Error_Section = 4'b0001;
    tick();
    Error_Section = '0;
    tick();
    tick();
    check("midrun_state", dbg_state, 2);
    check("midrun_err_count", err_count, 1);
    nReset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_outs", {section_en, clear_state, done}, 0);
    check("midrst_buf", be1_buf, 0);
    check("midrst_hard_err", {hard_bit, err_count}, 0);
    @(negedge Clock);
    nReset = 1'b1;
    tick();

    // Saturation: every RUN cycle errors for 300 events.
    start = 1'b1;
    tick();
    start = 1'b0;
    Error_Section = 4'b1000;
    done_seen = 0;
    for (int c = 0; c < 905; c++) begin
      if (done) done_seen++;
      tick();
    end
    check("sat_err_count", err_count, 255);
    check("sat_no_done", done_seen, 0);
    check("sat_busy", busy, 1);
    nReset = 1'b0;
    #1;
    check("sat_rst_state", dbg_state, 0);
    check("sat_rst_err_count", err_count, 0);
    Error_Section = '0;
    @(negedge Clock);
    nReset = 1'b1;
    tick();
    run_frame(vecs[2].be1, vecs[2].bsv, vecs[2].ba1v, -10, '0, '0, -10,
              clr_c, en_c, done_c, buf_e);
    check("recover_done_cyc", done_c, 6);
    check("recover_hard", hard_bit, vecs[2].exp_hard);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
